gf180mcu_fd_sc_mcu7t5v0__xnor_match: RTL and testbench
======================================================

// Module: gf180mcu_fd_sc_mcu7t5v0__xnor_match
// PURPOSE
//  Parametrised, registered successor to the 2-input XNOR cell.
//  - Computes a WIDTH-bit bitwise XNOR of A1/A2 each accepted beat.
//  - Counts the matching bits of each beat (POP).
//  - Accumulates POP over a multi-beat frame and flags frames whose total reaches THRESH.
//  - Used as a pattern-correlation / equality-scoring macro between datapath and control logic.
// PARAMETERS
//  WIDTH     8                            bits per beat on A1/A2/ZN
//  MAXBEATS  16                           max beats per frame; forced frame end at this count
//  THRESH    WIDTH*MAXBEATS/2             HIT threshold on accumulated match count
//  POPW      $clog2(WIDTH+1)              width of POP (derived localparam)
//  ACCW      $clog2(WIDTH*MAXBEATS+1)     width of ACC (derived localparam)
// PORTS
//  CLK    in   1      clock, rising edge
//  RST    in   1      asynchronous reset, active-high
//  A1     in   WIDTH  operand 1
//  A2     in   WIDTH  operand 2
//  IVLD   in   1      input beat valid
//  ILAST  in   1      input beat is last of frame; qualified by IVLD
//  IRDY   out  1      input ready
//  ZN     out  WIDTH  registered ~(A1^A2) of the beat
//  POP    out  POPW   number of 1s in ZN
//  ACC    out  ACCW   running frame match count, including this beat
//  OLAST  out  1      output beat closes its frame
//  HIT    out  1      ACC>=THRESH; meaningful only when OLAST=1, else 0
//  OVF    out  1      frame was force-closed at MAXBEATS without ILAST
//  OVLD   out  1      output beat valid
//  ORDY   in   1      downstream ready
// BEHAVIOUR
//  - Reset (async assert, sync-release use):
//    - All outputs are 0: ZN, POP, ACC, OLAST, HIT, OVF, OVLD.
//    - Running sum and beat counter are 0.
//    - IRDY follows its equation, so it is 1 while in reset.
//  - Handshake: single-stage valid/ready pipeline.
//    - IRDY = ~OVLD | ORDY (combinational).
//    - Input accepted when IVLD & IRDY; output transferred when OVLD & ORDY.
//    - Latency: beat accepted in cycle N appears with OVLD=1 in cycle N+1.
//    - Full throughput, one beat per cycle, while ORDY=1.
//    - While OVLD & ~ORDY: all outputs hold stable; no input is accepted.
//    - On transfer without a new accept, OVLD falls to 0.
//  - Per accepted beat:
//    - ZN <= ~(A1^A2); POP <= popcount of that value.
//    - ACC <= sum + popcount; beat count cnt <= cnt+1.
//    - Frame end fe = ILAST | (cnt==MAXBEATS-1).
//    - OLAST <= fe; OVF <= fe & ~ILAST.
//    - HIT <= fe & (sum+popcount >= THRESH).
//    - If fe: sum and cnt <= 0 and the next beat starts a new frame. Else sum <= ACC value, cnt advances.
//  - Width: ACC can never exceed WIDTH*MAXBEATS, so no wrap is possible; no saturation logic is needed.
//  - A beat arriving with ILAST=1 exactly at cnt==MAXBEATS-1 is a normal end: OVF=0.
//  - IVLD=0 (bubbles) mid-frame: sum and cnt are held; the frame continues.
//  - RST mid-frame: the partial frame is discarded with no OLAST emitted. The first beat after reset starts a new frame.
//  - ILAST and A1/A2 are ignored when IVLD=0.
// STRUCTURE
//  - Shared include gf180mcu_fd_sc_mcu7t5v0__xnor_match_pkg.vh holds:
//    - default WIDTH/MAXBEATS;
//    - POPW/ACCW clog2 helper function;
//    - reset-value constants.
//  - One sub-module, gf180mcu_fd_sc_mcu7t5v0__popcnt #(WIDTH): purely combinational adder-tree popcount.
//  - Top level holds: XNOR array, output registers, frame sum/count registers, handshake logic.
//  - specify block: A1/A2 -> ZN comb arcs are replaced by CLK -> outputs arcs.
// TESTING  (WIDTH=8, MAXBEATS=4, THRESH=20)
//  1. Reset: RST=1 with IVLD=1 -> OVLD=0, ZN=0, ACC=0, IRDY=1. After release, no output appears until the first accept.
//  2. Single beat A1=0xF0, A2=0xF0, ILAST=1 -> next cycle ZN=0xFF, POP=8, ACC=8, OLAST=1, HIT=0, OVF=0.
//  3. Frame (0xFF,0xFF), (0xAA,0x55), (0x0F,0x0F)+ILAST -> POP 8,0,8; ACC 8,8,16; OLAST only on beat 3; HIT=0.
//  4. Backpressure: ORDY=0 for 3 cycles while OVLD=1 -> IRDY=0 and outputs frozen. Then ORDY=1 -> every beat delivered once, in order.
//  5. Overflow: 4 matching beats, no ILAST -> beat 4 has ACC=32, OLAST=1, OVF=1, HIT=1. A 5th matching beat gives ACC=8 (new frame).
//  6. RST pulse after 2 beats of a frame -> OVLD=0 asynchronously. The next beat (0x00,0x00)+ILAST gives ACC=8, OLAST=1.

Source files
------------

// File: rtl/gf180mcu_fd_sc_mcu7t5v0__xnor_match_pkg.sv
// Shared definitions for the XNOR match macro.
//   - Default beat width and frame length.
//   - Ceiling-log2 helper used to size the POP, ACC and beat-count fields.
//   - Reset values of the output and frame-state registers.
package gf180mcu_fd_sc_mcu7t5v0__xnor_match_pkg;

    localparam int DEF_WIDTH    = 8;
    localparam int DEF_MAXBEATS = 16;

    // Reset values of the control and frame-state registers.
    localparam logic RST_VLD   = 1'b0;
    localparam logic RST_FLAG  = 1'b0;

    // Smallest r such that 2**r >= v. Returns 0 for v <= 1.
    function automatic int clog2_f(input int v);
        int r;
        r = 0;
        while ((1 << r) < v) begin
            r = r + 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/gf180mcu_fd_sc_mcu7t5v0__popcnt.sv
// Combinational population count built as a balanced adder tree.
// Ports:
//   a    in   WIDTH  input vector
//   pop  out  POPW   number of 1 bits in a
module gf180mcu_fd_sc_mcu7t5v0__popcnt
    import gf180mcu_fd_sc_mcu7t5v0__xnor_match_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    localparam int POPW = clog2_f(WIDTH + 1)
) (
    input  logic [WIDTH-1:0] a,
    output logic [POPW-1:0]  pop
);

    // Leaves padded to a power of two so the tree is a complete binary heap:
    // node i sums children 2i+1 and 2i+2; leaves occupy N-1 .. 2N-2.
    localparam int LVLS = clog2_f(WIDTH);
    localparam int N    = 1 << LVLS;

    always_comb begin
        logic [POPW-1:0] node [0:2*N-2];
        for (int i = 0; i < 2*N-1; i++) begin
            node[i] = '0;
        end
        for (int i = 0; i < WIDTH; i++) begin
            node[N-1+i] = POPW'(a[i]);
        end
        // Partial sums never exceed WIDTH, so POPW bits hold every node.
        for (int i = N-2; i >= 0; i--) begin
            node[i] = node[2*i+1] + node[2*i+2];
        end
        pop = node[0];
    end

endmodule

// File: rtl/gf180mcu_fd_sc_mcu7t5v0__xnor_match.sv
// Registered XNOR match scorer.
// Each accepted beat produces ZN = ~(A1^A2), its popcount POP, and the running
// frame total ACC. A frame ends on ILAST or when MAXBEATS beats have been taken;
// the closing beat carries OLAST, HIT (ACC >= THRESH) and OVF (forced close).
// Ports:
//   CLK    in   1      clock, rising edge
//   RST    in   1      asynchronous reset, active-high
//   A1,A2  in   WIDTH  operands
//   IVLD   in   1      input beat valid
//   ILAST  in   1      input beat closes its frame (qualified by IVLD)
//   IRDY   out  1      input ready
//   ZN     out  WIDTH  registered bitwise XNOR
//   POP    out  POPW   number of 1s in ZN
//   ACC    out  ACCW   running frame match count including this beat
//   OLAST  out  1      output beat closes its frame
//   HIT    out  1      frame total reached THRESH (only with OLAST)
//   OVF    out  1      frame was force-closed at MAXBEATS
//   OVLD   out  1      output beat valid
//   ORDY   in   1      downstream ready
module gf180mcu_fd_sc_mcu7t5v0__xnor_match
    import gf180mcu_fd_sc_mcu7t5v0__xnor_match_pkg::*;
#(
    parameter int WIDTH    = DEF_WIDTH,
    parameter int MAXBEATS = DEF_MAXBEATS,
    parameter int THRESH   = WIDTH * MAXBEATS / 2,
    localparam int POPW    = clog2_f(WIDTH + 1),
    localparam int ACCW    = clog2_f(WIDTH * MAXBEATS + 1)
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic [WIDTH-1:0] A1,
    input  logic [WIDTH-1:0] A2,
    input  logic             IVLD,
    input  logic             ILAST,
    output logic             IRDY,
    output logic [WIDTH-1:0] ZN,
    output logic [POPW-1:0]  POP,
    output logic [ACCW-1:0]  ACC,
    output logic             OLAST,
    output logic             HIT,
    output logic             OVF,
    output logic             OVLD,
    input  logic             ORDY
);

    localparam int CNTW = (clog2_f(MAXBEATS) < 1) ? 1 : clog2_f(MAXBEATS);

    logic [WIDTH-1:0] xnor_v;
    logic [POPW-1:0]  pop_v;
    logic [ACCW-1:0]  sum;
    logic [ACCW-1:0]  sum_next;
    logic [CNTW-1:0]  cnt;
    logic             frame_end;
    logic             accept;

    assign xnor_v = ~(A1 ^ A2);

    gf180mcu_fd_sc_mcu7t5v0__popcnt #(.WIDTH(WIDTH)) u_popcnt (
        .a   (xnor_v),
        .pop (pop_v)
    );

    // ACC is bounded by WIDTH*MAXBEATS, which ACCW is sized to hold, so the
    // running sum cannot wrap.
    assign sum_next  = sum + ACCW'(pop_v);
    assign frame_end = ILAST | (cnt == CNTW'(MAXBEATS - 1));

    // Single-stage skid-free pipeline: accept whenever the output slot is
    // empty or being drained this cycle.
    assign IRDY   = ~OVLD | ORDY;
    assign accept = IVLD & IRDY;

    // Stage boundary: input beat -> registered output beat
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            ZN    <= '0;
            POP   <= '0;
            ACC   <= '0;
            OLAST <= RST_FLAG;
            HIT   <= RST_FLAG;
            OVF   <= RST_FLAG;
            OVLD  <= RST_VLD;
            sum   <= '0;
            cnt   <= '0;
        end else if (accept) begin
            ZN    <= xnor_v;
            POP   <= pop_v;
            ACC   <= sum_next;
            OLAST <= frame_end;
            HIT   <= frame_end & (sum_next >= ACCW'(THRESH));
            OVF   <= frame_end & ~ILAST;
            OVLD  <= 1'b1;
            if (frame_end) begin
                sum <= '0;
                cnt <= '0;
            end else begin
                sum <= sum_next;
                cnt <= cnt + 1'b1;
            end
        end else if (ORDY) begin
            OVLD  <= 1'b0;
        end
    end

endmodule

// File: tb/tb_gf180mcu_fd_sc_mcu7t5v0__xnor_match.sv
module tb_gf180mcu_fd_sc_mcu7t5v0__xnor_match;

    localparam int WIDTH    = 8;
    localparam int MAXBEATS = 4;
    localparam int THRESH   = 20;
    localparam int POPW     = 4;
    localparam int ACCW     = 6;

    typedef struct packed {
        logic [WIDTH-1:0] zn;
        logic [POPW-1:0]  pop;
        logic [ACCW-1:0]  acc;
        logic             olast;
        logic             hit;
        logic             ovf;
    } exp_t;

    logic             CLK = 1'b0;
    logic             RST;
    logic [WIDTH-1:0] A1, A2;
    logic             IVLD, ILAST, IRDY;
    logic [WIDTH-1:0] ZN;
    logic [POPW-1:0]  POP;
    logic [ACCW-1:0]  ACC;
    logic             OLAST, HIT, OVF, OVLD, ORDY;

    int   n_cmp  = 0;
    int   n_fail = 0;
    exp_t exp_q[$];

    gf180mcu_fd_sc_mcu7t5v0__xnor_match #(
        .WIDTH(WIDTH), .MAXBEATS(MAXBEATS), .THRESH(THRESH)
    ) dut (
        .CLK(CLK), .RST(RST), .A1(A1), .A2(A2), .IVLD(IVLD), .ILAST(ILAST),
        .IRDY(IRDY), .ZN(ZN), .POP(POP), .ACC(ACC), .OLAST(OLAST), .HIT(HIT),
        .OVF(OVF), .OVLD(OVLD), .ORDY(ORDY)
    );

    always #5 CLK = ~CLK;

    function automatic exp_t mk(input logic [7:0] zn, input int pop, input int acc,
                                input logic olast, input logic hit, input logic ovf);
        exp_t e;
        e.zn = zn; e.pop = POPW'(pop); e.acc = ACCW'(acc);
        e.olast = olast; e.hit = hit; e.ovf = ovf;
        return e;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        n_cmp++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, req);
        end
    endtask

    // Present a beat, hold it until accepted, then queue its expected output.
    task automatic send(input logic [7:0] a1, input logic [7:0] a2, input logic last,
                        input exp_t e);
        bit ok;
        int tries;
        ok = 0; tries = 0;
        A1 = a1; A2 = a2; ILAST = last; IVLD = 1'b1;
        while (!ok && tries < 100) begin
            @(negedge CLK);
            ok = IRDY;
            @(posedge CLK);
            #1;
            tries++;
        end
        IVLD = 1'b0; ILAST = 1'b0;
        if (ok) exp_q.push_back(e);
        else begin
            n_cmp++; n_fail++;
            $display("FAIL accept_timeout: beat %h/%h never accepted", a1, a2);
        end
    endtask

    // Monitor: a transfer occurs at the next rising edge when OVLD & ORDY.
    initial begin
        exp_t e, act;
        forever begin
            @(negedge CLK);
            if (!RST && OVLD && ORDY) begin
                act = {ZN, POP, ACC, OLAST, HIT, OVF};
                if (exp_q.size() == 0) begin
                    n_cmp++; n_fail++;
                    $display("FAIL unexpected_beat: got %h with nothing expected", act);
                end else begin
                    e = exp_q.pop_front();
                    chk("beat", 32'(act), 32'(e));
                end
            end
        end
    end

    initial begin
        int w;
        RST = 1'b1; ORDY = 1'b1; IVLD = 1'b1; ILAST = 1'b1; A1 = 8'h12; A2 = 8'h34;

        // Reset with IVLD high
        repeat (2) @(negedge CLK);
        chk("rst_ovld", 32'(OVLD), 0);
        chk("rst_zn",   32'(ZN),   0);
        chk("rst_acc",  32'(ACC),  0);
        chk("rst_irdy", 32'(IRDY), 1);
        IVLD = 1'b0; ILAST = 1'b0;
        @(posedge CLK); #1; RST = 1'b0;
        repeat (3) @(negedge CLK);
        chk("idle_ovld", 32'(OVLD), 0);
        @(posedge CLK); #1;

        // Single-beat frame
        send(8'hF0, 8'hF0, 1, mk(8'hFF, 8, 8, 1, 0, 0));
        repeat (2) @(posedge CLK); #1;

        // Three-beat frame
        send(8'hFF, 8'hFF, 0, mk(8'hFF, 8, 8,  0, 0, 0));
        send(8'hAA, 8'h55, 0, mk(8'h00, 0, 8,  0, 0, 0));
        send(8'h0F, 8'h0F, 1, mk(8'hFF, 8, 16, 1, 0, 0));
        repeat (2) @(posedge CLK); #1;

        // Backpressure: first beat sits in the output slot for three cycles
        ORDY = 1'b0;
        fork
            begin
                send(8'h33, 8'h33, 0, mk(8'hFF, 8, 8,  0, 0, 0));
                send(8'h01, 8'h00, 0, mk(8'hFE, 7, 15, 0, 0, 0));
                send(8'h00, 8'hFF, 1, mk(8'h00, 0, 15, 1, 0, 0));
            end
        join_none
        w = 0;
        do begin @(negedge CLK); w++; end while (!OVLD && w < 20);
        for (int i = 0; i < 3; i++) begin
            chk("stall_irdy", 32'(IRDY), 0);
            chk("stall_ovld", 32'(OVLD), 1);
            chk("stall_zn",   32'(ZN),   32'hFF);
            chk("stall_acc",  32'(ACC),  8);
            @(negedge CLK);
        end
        @(posedge CLK); #1;
        ORDY = 1'b1;
        wait fork;
        repeat (2) @(posedge CLK); #1;

        // Forced close at MAXBEATS, then a fresh frame
        send(8'h55, 8'h55, 0, mk(8'hFF, 8, 8,  0, 0, 0));
        send(8'h55, 8'h55, 0, mk(8'hFF, 8, 16, 0, 0, 0));
        send(8'h55, 8'h55, 0, mk(8'hFF, 8, 24, 0, 0, 0));
        send(8'h55, 8'h55, 0, mk(8'hFF, 8, 32, 1, 1, 1));
        send(8'h55, 8'h55, 1, mk(8'hFF, 8, 8,  1, 0, 0));

        // ILAST exactly on the MAXBEATS-th beat is a normal close
        send(8'hFF, 8'h00, 0, mk(8'h00, 0, 0,  0, 0, 0));
        send(8'hFF, 8'hFF, 0, mk(8'hFF, 8, 8,  0, 0, 0));
        send(8'hF0, 8'h0F, 0, mk(8'h00, 0, 8,  0, 0, 0));
        send(8'h0F, 8'h0F, 1, mk(8'hFF, 8, 16, 1, 0, 0));

        // Bubbles mid-frame hold the running sum
        send(8'hC3, 8'hC3, 0, mk(8'hFF, 8, 8,  0, 0, 0));
        repeat (3) @(posedge CLK); #1;
        send(8'hC3, 8'h3C, 1, mk(8'h00, 0, 8,  1, 0, 0));
        repeat (2) @(posedge CLK); #1;

        // Reset mid-frame discards the partial sum
        send(8'hFF, 8'hFF, 0, mk(8'hFF, 8, 8,  0, 0, 0));
        send(8'hFF, 8'hFF, 0, mk(8'hFF, 8, 16, 0, 0, 0));
        @(negedge CLK);
        chk("pre_rst_ovld", 32'(OVLD), 1);
        #2 RST = 1'b1;
        #1 chk("async_rst_ovld", 32'(OVLD), 0);
        chk("async_rst_acc", 32'(ACC), 0);
        @(posedge CLK); #1; RST = 1'b0;
        send(8'h00, 8'h00, 1, mk(8'hFF, 8, 8, 1, 0, 0));

        w = 0;
        while (exp_q.size() != 0 && w < 50) begin @(posedge CLK); w++; end
        #1;
        chk("queue_drained", 32'(exp_q.size()), 0);
        repeat (2) @(posedge CLK);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
